// File: rtl/jtbubl_snd_comm_pkg.sv
// Shared register map, status bit positions and dispatcher state encoding
// for the main-CPU sound communication port.
package jtbubl_snd_comm_pkg;

   localparam logic [1:0] ADDR_CMD  = 2'd0;
   localparam logic [1:0] ADDR_CTRL = 2'd1;

   localparam int ST_BUSY  = 0;
   localparam int ST_REPLY = 1;
   localparam int ST_EMPTY = 2;
   localparam int ST_FULL  = 3;
   localparam int ST_OVF   = 4;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      LOAD     = 2'd1,
      STB      = 2'd2,
      WAIT_ACK = 2'd3
   } disp_state_e;

endpackage

// File: rtl/jtbubl_snd_fifo.sv
// Circular command FIFO, 2**AW entries; pointers carry one extra MSB so
// full and empty are distinguishable. Used with JTBUBL_SNDCOMM_FIFO_EN.
module jtbubl_snd_fifo #(
   parameter int AW = 2
)(
   input  logic       clk,
   input  logic       rstn,
   input  logic       flush,
   input  logic       push,
   input  logic       pop,
   input  logic [7:0] din,
   output logic [7:0] dout,
   output logic       full,
   output logic       empty
);

   logic [7:0]  mem_q [2**AW];
   logic [AW:0] wp_q, wp_d;
   logic [AW:0] rp_q, rp_d;

   assign empty = (wp_q == rp_q);
   assign full  = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
   assign dout  = mem_q[rp_q[AW-1:0]];

   always_comb begin
      wp_d = wp_q;
      rp_d = rp_q;
      if (flush) begin
         wp_d = '0;
         rp_d = '0;
      end else begin
         if (push) wp_d = wp_q + 1'b1;
         if (pop)  rp_d = rp_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wp_q <= '0;
         rp_q <= '0;
      end else begin
         wp_q <= wp_d;
         rp_q <= rp_d;
      end
   end

   // Storage needs no reset: pointers alone define valid contents.
   always_ff @(posedge clk) begin
      if (push && !flush) mem_q[wp_q[AW-1:0]] <= din;
   end

endmodule

// File: rtl/jtbubl_snd_comm.sv
// Main-CPU sound command port: buffers commands, dispatches them against the
// snd_flag handshake, latches replies. Macro JTBUBL_SNDCOMM_FIFO_EN selects a FIFO.
module jtbubl_snd_comm
   import jtbubl_snd_comm_pkg::*;
#(
   parameter int FIFO_AW = 2,
   parameter int TO_CNT  = 15
)(
   input  logic       clk,
   input  logic       rstn,
   input  logic       main_cs,
   input  logic [1:0] main_addr,
   input  logic       main_wr_n,
   input  logic       main_rd_n,
   input  logic [7:0] main_din,
   output logic [7:0] main_dout,
   output logic       main_irq_n,
   output logic [7:0] snd_latch,
   output logic       snd_stb,
   input  logic       snd_flag,
   input  logic [7:0] main_latch,
   input  logic       main_stb,
   output logic       snd_rstn
);

   localparam int TO_W = $clog2(TO_CNT + 1);

   disp_state_e     state_q;
   logic [TO_W-1:0] to_cnt_q;
   logic [7:0]      snd_latch_q;
   logic            snd_stb_q;

   logic wr_prev_q, rd_prev_q;
   logic snd_rstn_q, snd_rstn_d;
   logic irq_en_q, irq_en_d;
   logic irq_n_q, irq_n_d;
   logic [7:0] reply_q, reply_d;
   logic reply_pend_q, reply_pend_d;
   logic ovf_q, ovf_d;

   logic wr_acc, rd_acc, wr_pulse, rd_pulse;
   logic cmd_wr, ctrl_wr, cmd_rd, ctrl_rd;
   logic flush, push, pop, full, empty, busy;
   logic [7:0] head;

   assign wr_acc   = main_cs & ~main_wr_n;
   assign rd_acc   = main_cs & ~main_rd_n;
   assign wr_pulse = wr_acc & ~wr_prev_q;
   assign rd_pulse = rd_acc & ~rd_prev_q;
   assign cmd_wr   = wr_pulse && (main_addr == ADDR_CMD);
   assign ctrl_wr  = wr_pulse && (main_addr == ADDR_CTRL);
   assign cmd_rd   = rd_pulse && (main_addr == ADDR_CMD);
   assign ctrl_rd  = rd_pulse && (main_addr == ADDR_CTRL);

   assign flush = ctrl_wr & ~main_din[0];
   assign pop   = (state_q == LOAD) & ~flush;
   // A pop in the same cycle frees a slot, so a push into a full buffer still lands.
   assign push  = cmd_wr & (~full | pop);
   assign busy  = (state_q != IDLE) | ~snd_flag;

`ifdef JTBUBL_SNDCOMM_FIFO_EN
   jtbubl_snd_fifo #(.AW(FIFO_AW)) u_fifo (
      .clk   (clk),
      .rstn  (rstn),
      .flush (flush),
      .push  (push),
      .pop   (pop),
      .din   (main_din),
      .dout  (head),
      .full  (full),
      .empty (empty)
   );
`else
   logic [7:0] hold_q, hold_d;
   logic       hold_vld_q, hold_vld_d;
   logic       unused_fifo_aw;

   assign unused_fifo_aw = ^FIFO_AW;
   assign head  = hold_q;
   assign empty = ~hold_vld_q;
   assign full  = hold_vld_q;

   always_comb begin
      hold_d     = hold_q;
      hold_vld_d = hold_vld_q;
      if (flush) begin
         hold_vld_d = 1'b0;
      end else begin
         if (pop) hold_vld_d = 1'b0;
         if (push) begin
            hold_d     = main_din;
            hold_vld_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         hold_q     <= 8'h00;
         hold_vld_q <= 1'b0;
      end else begin
         hold_q     <= hold_d;
         hold_vld_q <= hold_vld_d;
      end
   end
`endif

   always_comb begin
      snd_rstn_d   = snd_rstn_q;
      irq_en_d     = irq_en_q;
      reply_d      = reply_q;
      reply_pend_d = reply_pend_q;
      if (ctrl_wr) begin
         snd_rstn_d = main_din[0];
         irq_en_d   = main_din[1];
      end
      if (main_stb) begin
         reply_d      = main_latch;
         reply_pend_d = 1'b1;
      end else if (cmd_rd) begin
         reply_pend_d = 1'b0;
      end
      ovf_d   = (cmd_wr & ~push) | (ovf_q & ~ctrl_rd);
      irq_n_d = ~(reply_pend_q & irq_en_q);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_prev_q    <= 1'b0;
         rd_prev_q    <= 1'b0;
         snd_rstn_q   <= 1'b0;
         irq_en_q     <= 1'b0;
         irq_n_q      <= 1'b1;
         reply_q      <= 8'h00;
         reply_pend_q <= 1'b0;
         ovf_q        <= 1'b0;
      end else begin
         wr_prev_q    <= wr_acc;
         rd_prev_q    <= rd_acc;
         snd_rstn_q   <= snd_rstn_d;
         irq_en_q     <= irq_en_d;
         irq_n_q      <= irq_n_d;
         reply_q      <= reply_d;
         reply_pend_q <= reply_pend_d;
         ovf_q        <= ovf_d;
      end
   end

   // Dispatcher: a flush overrides any in-flight dispatch but keeps snd_latch.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q     <= IDLE;
         to_cnt_q    <= '0;
         snd_latch_q <= 8'h00;
         snd_stb_q   <= 1'b0;
      end else if (flush) begin
         state_q   <= IDLE;
         snd_stb_q <= 1'b0;
         to_cnt_q  <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               snd_stb_q <= 1'b0;
               if (!empty && snd_flag && snd_rstn_q) state_q <= LOAD;
            end
            LOAD: begin
               snd_latch_q <= head;
               snd_stb_q   <= 1'b1;
               state_q     <= STB;
            end
            STB: begin
               snd_stb_q <= 1'b0;
               to_cnt_q  <= '0;
               state_q   <= WAIT_ACK;
            end
            WAIT_ACK: begin
               if (!snd_flag || to_cnt_q == TO_W'(TO_CNT - 1)) state_q <= IDLE;
               else to_cnt_q <= to_cnt_q + 1'b1;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   always_comb begin
      case (main_addr)
         ADDR_CMD:  main_dout = reply_q;
         ADDR_CTRL: main_dout = {3'b000, ovf_q, full, empty, reply_pend_q, busy};
         default:   main_dout = 8'hFF;
      endcase
   end

   assign main_irq_n = irq_n_q;
   assign snd_latch  = snd_latch_q;
   assign snd_stb    = snd_stb_q;
   assign snd_rstn   = snd_rstn_q;

endmodule

// File: tb/tb_jtbubl_snd_comm.sv
// Directed bench for jtbubl_snd_comm with a small sound-side handshake model;
// expectations follow JTBUBL_SNDCOMM_FIFO_EN when defined.
module tb_jtbubl_snd_comm;

`ifdef JTBUBL_SNDCOMM_FIFO_EN
   localparam int DEPTH = 4;
`else
   localparam int DEPTH = 1;
`endif
   localparam int TO_CNT = 15;

   logic       clk = 1'b0;
   logic       rstn = 1'b0;
   logic       main_cs = 1'b0;
   logic [1:0] main_addr = 2'd0;
   logic       main_wr_n = 1'b1;
   logic       main_rd_n = 1'b1;
   logic [7:0] main_din = 8'h00;
   logic [7:0] main_dout;
   logic       main_irq_n;
   logic [7:0] snd_latch;
   logic       snd_stb;
   logic       snd_flag = 1'b1;
   logic [7:0] main_latch = 8'h00;
   logic       main_stb = 1'b0;
   logic       snd_rstn;

   always #5 clk = ~clk;

   jtbubl_snd_comm #(.FIFO_AW(2), .TO_CNT(TO_CNT)) dut (
      .clk        (clk),
      .rstn       (rstn),
      .main_cs    (main_cs),
      .main_addr  (main_addr),
      .main_wr_n  (main_wr_n),
      .main_rd_n  (main_rd_n),
      .main_din   (main_din),
      .main_dout  (main_dout),
      .main_irq_n (main_irq_n),
      .snd_latch  (snd_latch),
      .snd_stb    (snd_stb),
      .snd_flag   (snd_flag),
      .main_latch (main_latch),
      .main_stb   (main_stb),
      .snd_rstn   (snd_rstn)
   );

   int nvec = 0, nerr = 0, ncyc = 0, last_wr_cyc = 0, long_err = 0;
   logic prev_stb = 1'b0;
   logic [7:0] stb_v[$];
   int stb_t[$];
   logic model_en = 1'b0, model_pend = 1'b0;
   int model_drop = 0, model_low = 0, drop_cnt = 0, low_cnt = 0;

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %02h expected %02h", tag, got, exp);
      end
   endtask

   // One clock; at the falling edge log strobes and run the sound-side model.
   task automatic step();
      @(posedge clk);
      @(negedge clk);
      ncyc++;
      if (snd_stb) begin
         stb_v.push_back(snd_latch);
         stb_t.push_back(ncyc);
         if (prev_stb) long_err++;
      end
      prev_stb = snd_stb;
      if (model_en && snd_stb) begin
         drop_cnt   = model_drop;
         model_pend = 1'b1;
      end
      if (model_pend) begin
         if (drop_cnt == 0) begin
            snd_flag   = 1'b0;
            model_pend = 1'b0;
            low_cnt    = model_low;
         end else drop_cnt--;
      end else if (low_cnt > 0) begin
         low_cnt--;
         if (low_cnt == 0) snd_flag = 1'b1;
      end
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic wr(input logic [1:0] a, input logic [7:0] d);
      main_cs = 1'b1; main_wr_n = 1'b0; main_addr = a; main_din = d;
      last_wr_cyc = ncyc;
      step();
      main_cs = 1'b0; main_wr_n = 1'b1;
      step();
   endtask

   task automatic rd(input logic [1:0] a, output logic [7:0] d);
      main_cs = 1'b1; main_rd_n = 1'b0; main_addr = a;
      #1 d = main_dout;
      step();
      main_cs = 1'b0; main_rd_n = 1'b1;
      step();
   endtask

   task automatic peek(input logic [1:0] a, output logic [7:0] d);
      main_addr = a;
      #1 d = main_dout;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [7:0] v;
      int n2;
      logic found;

      // Reset state
      steps(2);
      rstn = 1'b1;
      step();
      chk("rst_irq_n", 8'(main_irq_n), 8'h01);
      chk("rst_stb", 8'(snd_stb), 8'h00);
      chk("rst_snd_rstn", 8'(snd_rstn), 8'h00);
      chk("rst_latch", snd_latch, 8'h00);
      peek(2'd1, v); chk("rst_status", v, 8'h04);
      peek(2'd0, v); chk("rst_reply", v, 8'h00);
      peek(2'd2, v); chk("addr2_ff", v, 8'hFF);

      // Single command: strobe timing and width
      wr(2'd1, 8'h01);
      model_en = 1'b1; model_drop = 2; model_low = 3;
      stb_v.delete(); stb_t.delete();
      wr(2'd0, 8'h5A);
      steps(12);
      chk("t1_count", 8'(stb_v.size()), 8'h01);
      if (stb_v.size() > 0) begin
         chk("t1_latch", stb_v[0], 8'h5A);
         chk("t1_latency", 8'(stb_t[0] - last_wr_cyc), 8'h03);
      end
      peek(2'd1, v); chk("t1_idle_status", v, 8'h04);

      // Back-to-back pushes with a slow sound side
      model_drop = 0; model_low = 20;
      stb_v.delete(); stb_t.delete();
      wr(2'd0, 8'h11); wr(2'd0, 8'h22); wr(2'd0, 8'h33);
      steps(100);
      n2 = (DEPTH > 1) ? 3 : 2;
      chk("t2_count", 8'(stb_v.size()), 8'(n2));
      for (int i = 0; i < stb_v.size() && i < n2; i++)
         chk("t2_order", stb_v[i], 8'(8'h11 * (i + 1)));
      for (int i = 1; i < stb_v.size(); i++)
         chk("t2_gap", 8'(stb_t[i] - stb_t[i-1] >= 20), 8'h01);
      rd(2'd1, v); chk("t2_status", v, (DEPTH > 1) ? 8'h04 : 8'h14);

      // Overflow while sound side is stalled, then drain
      model_en = 1'b0; snd_flag = 1'b0;
      stb_v.delete(); stb_t.delete();
      for (int i = 0; i <= DEPTH; i++) wr(2'd0, 8'(8'hA0 + i));
      rd(2'd1, v); chk("t3_status_ovf", v, 8'h19);
      rd(2'd1, v); chk("t3_status_clr", v, 8'h09);
      model_en = 1'b1; model_drop = 0; model_low = 3; snd_flag = 1'b1;
      steps(60);
      chk("t3_drain_count", 8'(stb_v.size()), 8'(DEPTH));
      for (int i = 0; i < stb_v.size() && i < DEPTH; i++)
         chk("t3_drain_data", stb_v[i], 8'(8'hA0 + i));

      // Reply path and interrupt
      model_en = 1'b0;
      wr(2'd1, 8'h03);
      main_latch = 8'hC3; main_stb = 1'b1;
      step();
      main_stb = 1'b0;
      step();
      chk("t4_irq_low", 8'(main_irq_n), 8'h00);
      rd(2'd0, v); chk("t4_reply", v, 8'hC3);
      chk("t4_irq_high", 8'(main_irq_n), 8'h01);
      main_latch = 8'h7E; main_stb = 1'b1;
      main_cs = 1'b1; main_rd_n = 1'b0; main_addr = 2'd0;
      #1 v = main_dout;
      chk("t4_coinc_read", v, 8'hC3);
      step();
      main_stb = 1'b0; main_cs = 1'b0; main_rd_n = 1'b1;
      peek(2'd1, v); chk("t4_pend_kept", v & 8'h02, 8'h02);
      peek(2'd0, v); chk("t4_new_reply", v, 8'h7E);
      step();
      chk("t4_irq_again", 8'(main_irq_n), 8'h00);

      // Ack timeout: stuck snd_flag, next byte follows after TO_CNT cycles
      stb_v.delete(); stb_t.delete();
      snd_flag = 1'b1;
      wr(2'd0, 8'hB1); wr(2'd0, 8'hB2);
      steps(60);
      chk("t5_count", 8'(stb_v.size()), 8'h02);
      if (stb_v.size() == 2) begin
         chk("t5_first", stb_v[0], 8'hB1);
         chk("t5_second", stb_v[1], 8'hB2);
         chk("t5_gap", 8'(stb_t[1] - stb_t[0]), 8'(TO_CNT + 3));
      end
      peek(2'd1, v); chk("t5_status", v, 8'h06);

      // Flush on sound reset
      snd_flag = 1'b0;
      wr(2'd0, 8'hC1); wr(2'd0, 8'hC2);
      wr(2'd1, 8'h00);
      peek(2'd1, v); chk("t5_flush_status", v, (DEPTH > 1) ? 8'h07 : 8'h17);
      chk("t5_flush_rstn", 8'(snd_rstn), 8'h00);
      stb_v.delete(); stb_t.delete();
      snd_flag = 1'b1;
      wr(2'd1, 8'h03);
      steps(30);
      chk("t5_no_stb", 8'(stb_v.size()), 8'h00);
      chk("t5_latch_kept", snd_latch, 8'hB2);

      // Asynchronous reset while the strobe is high
      wr(2'd0, 8'hD4);
      found = 1'b0;
      for (int i = 0; i < 10 && !found; i++) begin
         step();
         found = snd_stb;
      end
      chk("t6_stb_seen", 8'(found), 8'h01);
      chk("t6_irq_before", 8'(main_irq_n), 8'h00);
      #1 rstn = 1'b0;
      #1;
      chk("t6_stb", 8'(snd_stb), 8'h00);
      chk("t6_snd_rstn", 8'(snd_rstn), 8'h00);
      chk("t6_irq_n", 8'(main_irq_n), 8'h01);
      chk("t6_latch", snd_latch, 8'h00);
      peek(2'd1, v); chk("t6_status", v, 8'h04);
      step();
      rstn = 1'b1;
      step();

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
